// File: rtl/hpdcache_mem_req_read_credit_arbiter_if.sv
// ----------------------------------------------------------------------------
// hpdcache_mem_req_read_credit_arbiter_if
//
// Purpose: bundles the requester-side handshake, the shared memory read
// request channel and the credit-return strobe used by the read credit
// arbiter.
//
// Signals:
//   req_valid     [N-1:0]            per-requester request valid
//   req_ready     [N-1:0]            per-requester ready back to requester
//   req           N x payload        per-requester request payload
//   mem_req_ready                    memory channel ready
//   mem_req_valid                    memory channel valid
//   mem_req       payload            granted payload
//   mem_req_src   [SRC_W-1:0]        index of the granted requester
//   rsp_done                         one read response completed
//   rsp_src       [SRC_W-1:0]        requester owning the completed response
//
// Modports:
//   slave  - arbiter view
//   master - environment view (requesters + memory + response path)
// ----------------------------------------------------------------------------
interface hpdcache_mem_req_read_credit_arbiter_if #(
   parameter int unsigned N     = 4,
   parameter type hpdcache_mem_req_t = logic,
   parameter int unsigned SRC_W = (N > 1) ? $clog2(N) : 1
);
   logic [N-1:0]       req_valid;
   logic [N-1:0]       req_ready;
   hpdcache_mem_req_t  req [N];
   logic               mem_req_ready;
   logic               mem_req_valid;
   hpdcache_mem_req_t  mem_req;
   logic [SRC_W-1:0]   mem_req_src;
   logic               rsp_done;
   logic [SRC_W-1:0]   rsp_src;

   modport slave (
      input  req_valid,
      input  req,
      input  mem_req_ready,
      input  rsp_done,
      input  rsp_src,
      output req_ready,
      output mem_req_valid,
      output mem_req,
      output mem_req_src
   );

   modport master (
      output req_valid,
      output req,
      output mem_req_ready,
      output rsp_done,
      output rsp_src,
      input  req_ready,
      input  mem_req_valid,
      input  mem_req,
      input  mem_req_src
   );
endinterface

// File: rtl/hpdcache_mem_req_read_credit_arbiter.sv
// ----------------------------------------------------------------------------
// hpdcache_mem_req_read_credit_arbiter
//
// Purpose: shares the single memory read-request channel between N
// requesters with round-robin priority. Each requester owns a credit counter
// of in-flight reads, capped at MAX_OUTSTANDING; credits come back through
// rsp_done/rsp_src. Once offered, a grant is held stable until the memory
// channel accepts it.
//
// Ports:
//   clk_i          clock
//   rst_i          synchronous reset, active-high
//   arb_if         requester / memory / credit-return bundle (slave modport)
//   busy_o         any requester has reads in flight
//   err_o          sticky: credit returned to a requester with none in flight
//   stat_stall_o   cycles with mem_req_valid=1 and mem_req_ready=0 (saturating)
//
// Build option:
//   HPDCACHE_MEM_ARB_STATS_EN  when defined, stat_stall_o is a live saturating
//                              counter; otherwise it is tied to 0 and the
//                              counter flops do not exist.
//
// State   | meaning
// --------+------------------------------------------------------------------
// IDLE    | grant follows round-robin search from ptr over eligible requests
// LOCKED  | an offered request was not accepted; grant pinned to lock_idx
// ----------------------------------------------------------------------------
module hpdcache_mem_req_read_credit_arbiter #(
   parameter int unsigned N               = 4,
   parameter int unsigned MAX_OUTSTANDING = 8,
   parameter type hpdcache_mem_req_t      = logic,
   parameter int unsigned SRC_W           = (N > 1) ? $clog2(N) : 1,
   parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                                          clk_i,
   input  logic                                          rst_i,
   hpdcache_mem_req_read_credit_arbiter_if.slave         arb_if,
   output logic                                          busy_o,
   output logic                                          err_o,
   output logic [31:0]                                   stat_stall_o
);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

   state_t            state_q, state_d;
   logic [SRC_W-1:0]  lock_idx_q, lock_idx_d;
   logic [SRC_W-1:0]  ptr_q, ptr_d;
   logic [CNT_W-1:0]  cnt_q [N];
   logic [CNT_W-1:0]  cnt_d [N];
   logic              err_q, err_d;

   logic [N-1:0]      elig;
   logic              rr_found;
   logic [SRC_W-1:0]  rr_idx;
   logic [SRC_W-1:0]  grant_idx;
   logic [N-1:0]      grant;
   logic              mem_valid;
   logic              hs;
   hpdcache_mem_req_t mem_req;
   logic [SRC_W-1:0]  mem_src;
   logic              busy;

   // A full requester is masked on the registered count only, so a credit
   // returned this cycle unmasks it from the next cycle on.
   always_comb begin
      elig = '0;
      for (int unsigned i = 0; i < N; i++) begin
         elig[i] = arb_if.req_valid[i] && (cnt_q[i] < CNT_MAX);
      end
   end

   // First eligible index at or after ptr, wrapping modulo N.
   always_comb begin : rr_search
      int unsigned cand;
      cand     = 0;
      rr_found = 1'b0;
      rr_idx   = '0;
      for (int unsigned k = 0; k < N; k++) begin
         cand = k + 32'(ptr_q);
         if (cand >= N) begin
            cand = cand - N;
         end
         if (!rr_found && elig[SRC_W'(cand)]) begin
            rr_found = 1'b1;
            rr_idx   = SRC_W'(cand);
         end
      end
   end

   // Valid is suppressed during reset so every output reads 0 while rst_i
   // is high, even with requesters still asserting valid.
   always_comb begin
      grant_idx = (state_q == ST_LOCKED) ? lock_idx_q : rr_idx;
      mem_valid = !rst_i && ((state_q == ST_LOCKED) || rr_found);
      hs        = mem_valid && arb_if.mem_req_ready;
      grant     = '0;
      for (int unsigned i = 0; i < N; i++) begin
         grant[i] = mem_valid && (grant_idx == SRC_W'(i));
      end
   end

   // One-hot AND-OR mux: with no grant the channel carries all zeros.
   always_comb begin
      mem_req = '0;
      mem_src = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (grant[i]) begin
            mem_req = mem_req | arb_if.req[i];
            mem_src = mem_src | SRC_W'(i);
         end
      end
   end

   assign arb_if.mem_req_valid = mem_valid;
   assign arb_if.mem_req       = mem_req;
   assign arb_if.mem_req_src   = mem_src;
   assign arb_if.req_ready     = grant & {N{arb_if.mem_req_ready}};

   // Arbitration FSM next state and round-robin pointer.
   always_comb begin
      state_d    = state_q;
      lock_idx_d = lock_idx_q;
      ptr_d      = ptr_q;
      if (hs) begin
         state_d = ST_IDLE;
         ptr_d   = (grant_idx == SRC_W'(N - 1)) ? '0 : grant_idx + SRC_W'(1);
      end else if (mem_valid && (state_q == ST_IDLE)) begin
         state_d    = ST_LOCKED;
         lock_idx_d = grant_idx;
      end
   end

   // Credit counters. An out-of-range rsp_src matches no index and is
   // therefore ignored. A return to an empty counter is flagged but never
   // wraps the counter; a return and an issue on the same index cancel.
   always_comb begin
      logic inc;
      logic ret;
      logic dec;
      inc   = 1'b0;
      ret   = 1'b0;
      dec   = 1'b0;
      err_d = err_q;
      for (int unsigned i = 0; i < N; i++) begin
         inc = hs && grant[i];
         ret = arb_if.rsp_done && (arb_if.rsp_src == SRC_W'(i));
         dec = ret && (cnt_q[i] != '0);
         if (ret && (cnt_q[i] == '0)) begin
            err_d = 1'b1;
         end
         cnt_d[i] = cnt_q[i];
         if (inc && !dec && (cnt_q[i] != CNT_MAX)) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end else if (dec && !inc) begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         lock_idx_q <= '0;
         ptr_q      <= '0;
         err_q      <= 1'b0;
         for (int unsigned i = 0; i < N; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         lock_idx_q <= lock_idx_d;
         ptr_q      <= ptr_d;
         err_q      <= err_d;
         for (int unsigned i = 0; i < N; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   always_comb begin
      busy = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         busy = busy | (cnt_q[i] != '0);
      end
   end

   assign busy_o = busy;
   assign err_o  = err_q;

`ifdef HPDCACHE_MEM_ARB_STATS_EN
   logic [31:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (mem_valid && !arb_if.mem_req_ready && (stall_q != 32'hFFFF_FFFF)) begin
         stall_d = stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stat_stall_o = stall_q;
`else
   assign stat_stall_o = '0;
`endif

endmodule
